// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer, one full-adder bit per clock, LSB first
//
// full_a          : single-bit full adder
//   a, b, cin     in   operand bits and carry-in
//   s, cout       out  sum bit and carry-out
//
// serial_add_ctrl : sequencer around one full_a instance
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while the add is in progress
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  last completed result
//   cout   out  1      last completed carry-out

module full_a (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, p_sh, p_nx;
   logic [CW-1:0]    count;
   logic             carry, s, co, accept, last;

   full_a u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(s), .cout(co));

   assign accept = start && state != RUN;
   assign last   = state == RUN && count == CW'(WIDTH - 1);
   // new sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB result
   assign p_nx   = (p_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
   assign busy   = state == RUN;
   assign done   = state == DONE;

   always_comb begin
      state_nx = state;
      if (accept)
         state_nx = RUN;
      else if (last)
         state_nx = DONE;
      else if (state == DONE)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         p_sh  <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         count <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         p_sh  <= p_nx;
         carry <= co;
         count <= count + CW'(1);
         if (last) begin
            sum  <= p_nx;
            cout <= co;
         end
      end
   end
endmodule
